stack_prog_loader: RTL and testbench

//  Writer side of the stack-machine instruction memory. Takes a framed byte stream on a valid/ready

---
 rtl/stack_isa_pkg.sv | 40 ++++
 rtl/stack_insn_check.sv | 22 ++
 rtl/stack_prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_stack_prog_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_isa_pkg.sv
// Shared ISA definitions for the stack machine: widths, opcodes, loader states
// and the error codes reported by the program loader.
package stack_isa_pkg;

  localparam int OPC_W  = 4;
  localparam int OPR_W  = 8;
  localparam int INSN_W = 12;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JMPF  = 4'd5;
  localparam logic [3:0] OP_JMPB  = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;
  localparam logic [3:0] OP_BLE   = 4'd9;
  localparam logic [3:0] OP_BLT   = 4'd10;
  localparam int         NUM_OPS  = 11;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_OPC  = 3'd1,
    S_OPR  = 3'd2,
    S_CSUM = 3'd3,
    S_RESP = 3'd4
  } ld_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BADOP = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_BOTH  = 2'd3;

  // Pack the two error flags into the reported error code.
  function automatic logic [1:0] err_pack(input logic csum_fail, input logic bad_op);
    err_pack = {csum_fail, bad_op};
  endfunction

endpackage

// File: rtl/stack_insn_check.sv
// Combinational opcode legality check. A byte is a legal opcode when its
// upper bits are zero and its opcode field is below NUM_OPS. Also used by
// the interpreter's illegal-op trap.
module stack_insn_check
  import stack_isa_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int NUM_OPS = 11
) (
  input  logic [7:0] opc_byte_i,
  output logic       legal_o
);

  localparam logic [OPC_W:0] OPS_LIM = (OPC_W + 1)'(NUM_OPS);

  // Upper bits must be clear and the opcode field must name an implemented op.
  always_comb begin
    legal_o = (opc_byte_i[7:OPC_W] == '0) &&
              ({1'b0, opc_byte_i[OPC_W-1:0]} < OPS_LIM);
  end

endmodule

// File: rtl/stack_prog_loader.sv
// Program loader for the stack-machine instruction memory. Accepts a framed
// byte stream (LEN, LEN x {OPC, OPR}, CSUM), writes legal instruction words
// into the program store and releases core_hold only after a clean frame.
module stack_prog_loader
  import stack_isa_pkg::*;
#(
  parameter int   ADDR_W    = 8,
  parameter int   OPR_W     = 8,
  parameter int   OPC_W     = 4,
  parameter int   NUM_OPS   = 11,
  parameter logic BOOT_HOLD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [OPR_W+OPC_W-1:0]   imem_wdata,
  output logic                     core_hold,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err,
  output logic [1:0]               err_code
);

  ld_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]          cnt_last_q, cnt_last_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [7:0]                 csum_q, csum_d;
  logic [OPC_W-1:0]           opc_q, opc_d;
  logic                       bad_word_q, bad_word_d;
  logic                       bad_op_q, bad_op_d;
  logic                       fail_q, fail_d;
  logic                       we_q, we_d;
  logic [ADDR_W-1:0]          waddr_q, waddr_d;
  logic [OPR_W+OPC_W-1:0]     wdata_q, wdata_d;
  logic                       hold_q, hold_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [1:0]                 code_q, code_d;
  logic                       legal_s;
  logic                       accept_s;

  stack_insn_check #(
    .OPC_W   (OPC_W),
    .NUM_OPS (NUM_OPS)
  ) u_insn_check (
    .opc_byte_i (in_data),
    .legal_o    (legal_s)
  );

  // The response cycle is the only one in which the stream is stalled.
  assign in_ready   = (state_q != S_RESP);
  assign busy       = (state_q != S_LEN);
  assign accept_s   = in_valid & in_ready;
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign err_code   = code_q;

  // Next-state logic: the frame FSM moves only on accepted bytes, except the
  // single response cycle which always completes.
  always_comb begin
    state_d    = state_q;
    cnt_last_d = cnt_last_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    opc_d      = opc_q;
    bad_word_d = bad_word_q;
    bad_op_d   = bad_op_q;
    fail_d     = fail_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    code_d     = code_q;

    case (state_q)
      S_LEN: begin
        if (accept_s) begin
          // LEN=0 wraps to the full address space through the subtraction.
          cnt_last_d = in_data[ADDR_W-1:0] - ADDR_W'(1);
          addr_d     = '0;
          csum_d     = in_data;
          bad_op_d   = 1'b0;
          fail_d     = 1'b0;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
          hold_d     = 1'b1;
          state_d    = S_OPC;
        end else begin
          state_d    = S_LEN;
        end
      end
      S_OPC: begin
        if (accept_s) begin
          opc_d      = in_data[OPC_W-1:0];
          bad_word_d = ~legal_s;
          csum_d     = csum_q ^ in_data;
          state_d    = S_OPR;
        end else begin
          state_d    = S_OPC;
        end
      end
      S_OPR: begin
        if (accept_s) begin
          csum_d = csum_q ^ in_data;
          // An illegal word keeps its slot but is never written.
          if (bad_word_q) begin
            bad_op_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {in_data[OPR_W-1:0], opc_q};
          end
          if (addr_q == cnt_last_q) begin
            state_d = S_CSUM;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_OPC;
          end
        end else begin
          state_d = S_OPR;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          fail_d  = ((csum_q ^ in_data) != 8'h00);
          state_d = S_RESP;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_RESP: begin
        code_d = err_pack(fail_q, bad_op_q);
        if (!fail_q && !bad_op_q) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end else begin
          err_d  = 1'b1;
          hold_d = 1'b1;
        end
        state_d = S_LEN;
      end
      default: begin
        state_d = S_LEN;
      end
    endcase
  end

  // State and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LEN;
      cnt_last_q <= '0;
      addr_q     <= '0;
      csum_q     <= 8'h00;
      opc_q      <= '0;
      bad_word_q <= 1'b0;
      bad_op_q   <= 1'b0;
      fail_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= BOOT_HOLD;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_last_q <= cnt_last_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
      opc_q      <= opc_d;
      bad_word_q <= bad_word_d;
      bad_op_q   <= bad_op_d;
      fail_q     <= fail_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: tb/tb_stack_prog_loader.sv
// Scoreboard bench for stack_prog_loader: the stimulus thread queues expected
// writes and frame responses; a monitor thread checks them as they appear.
module tb_stack_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  logic [19:0] wq[$];   // {addr, data}
  logic [4:0]  rq[$];   // {load_done, load_err, err_code, core_hold}
  int          vec_cnt;
  int          err_cnt;
  logic        prev_ready;
  logic [7:0]  cs;

  stack_prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [11:0] d);
    wq.push_back({a, d});
  endtask

  task automatic exp_resp(input logic done, input logic err, input logic [1:0] code, input logic hold);
    rq.push_back({done, err, code, hold});
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},   32'd1);
    chk({tag, "_imem_we"},   {31'd0, imem_we},    32'd0);
    chk({tag, "_imem_addr"}, {24'd0, imem_addr},  32'd0);
    chk({tag, "_imem_wdata"},{20'd0, imem_wdata}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},       32'd0);
    chk({tag, "_load_done"}, {31'd0, load_done},  32'd0);
    chk({tag, "_load_err"},  {31'd0, load_err},   32'd0);
    chk({tag, "_err_code"},  {30'd0, err_code},   32'd0);
    chk({tag, "_core_hold"}, {31'd0, core_hold},  32'd1);
  endtask

  // Queue and drive the clean two-word frame 02,00,05,03,00,04.
  task automatic clean_frame(input int gap);
    logic [7:0] fr [6];
    fr[0] = 8'h02; fr[1] = 8'h00; fr[2] = 8'h05;
    fr[3] = 8'h03; fr[4] = 8'h00; fr[5] = 8'h04;
    exp_wr(8'h00, 12'h050);
    exp_wr(8'h01, 12'h003);
    exp_resp(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(fr[i]);
      if (i == 0) begin
        chk("start_hold", {31'd0, core_hold}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
      end
      if (i < 5) begin
        for (int g = 0; g < gap; g++) begin
          idle(1);
          chk("gap_busy", {31'd0, busy}, 32'd1);
          chk("gap_ready", {31'd0, in_ready}, 32'd1);
        end
      end
    end
    idle(3);
  endtask

  task automatic monitor();
    logic [19:0] w;
    logic [4:0]  r;
    logic        resp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        resp = in_ready && !prev_ready;
        if (imem_we) begin
          if (wq.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", {24'd0, imem_addr}, {24'd0, w[19:12]});
            chk("wr_data", {20'd0, imem_wdata}, {20'd0, w[11:0]});
          end
        end
        if (resp) begin
          if (rq.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL resp_unexpected: got a frame response expected none");
          end else begin
            r = rq.pop_front();
            chk("resp_load_done", {31'd0, load_done}, {31'd0, r[4]});
            chk("resp_load_err",  {31'd0, load_err},  {31'd0, r[3]});
            chk("resp_err_code",  {30'd0, err_code},  {30'd0, r[2:1]});
            chk("resp_core_hold", {31'd0, core_hold}, {31'd0, r[0]});
          end
        end else if (load_done) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL stray_load_done: got 1 expected 0");
        end
      end
      prev_ready = in_ready;
    end
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    prev_ready = 1'b1;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    reset_chk("rst");
    rst_n = 1'b1;
    idle(1);

    // 1: clean frame
    clean_frame(0);
    chk("t1_hold", {31'd0, core_hold}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // 2: illegal opcode 0x0B, no write
    exp_resp(1'b0, 1'b1, 2'd1, 1'b1);
    send(8'h01); send(8'h0B); send(8'h10); send(8'h1A);
    idle(3);
    chk("t2_err", {31'd0, load_err}, 32'd1);
    chk("t2_code", {30'd0, err_code}, 32'd1);
    chk("t2_hold", {31'd0, core_hold}, 32'd1);

    // 3: bad checksum, word still written; then a clean frame clears the error
    exp_wr(8'h00, 12'h070);
    exp_resp(1'b0, 1'b1, 2'd2, 1'b1);
    send(8'h01); send(8'h00); send(8'h07); send(8'hFF);
    idle(3);
    chk("t3_code", {30'd0, err_code}, 32'd2);
    chk("t3_hold", {31'd0, core_hold}, 32'd1);
    clean_frame(0);
    chk("t3_err_cleared", {31'd0, load_err}, 32'd0);
    chk("t3_hold_released", {31'd0, core_hold}, 32'd0);

    // 4: LEN=0 means 256 words
    exp_resp(1'b1, 1'b0, 2'd0, 1'b0);
    cs = 8'h00;
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      exp_wr(8'(i), {8'(i), 4'h0});
      send(8'h00);
      send(8'(i));
      cs = cs ^ 8'(i);
    end
    send(cs);
    idle(3);
    chk("t4_hold", {31'd0, core_hold}, 32'd0);

    // 5: throttled clean frame
    clean_frame(3);
    chk("t5_hold", {31'd0, core_hold}, 32'd0);

    // 6: reset mid-frame after three bytes, then a clean load
    send(8'h02); send(8'h00); send(8'h05);
    rst_n = 1'b0;
    #1;
    reset_chk("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    clean_frame(0);
    chk("t6_hold", {31'd0, core_hold}, 32'd0);

    idle(5);
    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
